// File: rtl/umi_reg_host.sv
// umi_reg_host
// Turns single-register host accesses into single-flit UMI requests and
// returns read data and completion status to the host. Only one transaction
// is in flight at a time.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   host_valid/ready      host access handshake
//   host_write/posted     access type (read, write, posted write)
//   host_addr, host_wdata register byte address and write data
//   host_done             one-cycle completion pulse
//   host_rdata, host_err  read data and status, valid with host_done
//                         (err[0] = timeout, err[1] = response error)
//   uhost_req_*           UMI request channel (to device)
//   uhost_resp_*          UMI response channel (from device)
//
// Optional feature macro: UMI_REG_HOST_TIMEOUT_EN
//   When defined, a 16-bit counter bounds the response wait to TIMEOUT
//   cycles and flags err[0] on expiry. When undefined the host waits
//   indefinitely for a response and err[0] is always 0.
module umi_reg_host #(
    parameter int              DW      = 256,
    parameter int              AW      = 64,
    parameter int              CW      = 32,
    parameter int              RW      = 32,
    parameter logic [AW-1:0]   SRCADDR = {AW{1'b0}},
    parameter int              TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_valid,
    input  logic          host_write,
    input  logic          host_posted,
    input  logic [AW-1:0] host_addr,
    input  logic [RW-1:0] host_wdata,
    output logic          host_ready,
    output logic          host_done,
    output logic [RW-1:0] host_rdata,
    output logic [1:0]    host_err,
    output logic          uhost_req_valid,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_req_ready,
    input  logic          uhost_resp_valid,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data,
    output logic          uhost_resp_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [4:0] UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;

    localparam logic [2:0] REQ_SIZE = 3'($clog2(RW / 8));

    // UMI command layout: opcode[4:0], size[7:5], len[15:8], eom[22], eof[23];
    // every other field is left at zero.
    function automatic logic [CW-1:0] umi_pack(
        input logic [4:0] opcode,
        input logic [2:0] size,
        input logic [7:0] len,
        input logic       eom,
        input logic       eof
    );
        logic [CW-1:0] cmd;
        cmd        = {CW{1'b0}};
        cmd[4:0]   = opcode;
        cmd[7:5]   = size;
        cmd[15:8]  = len;
        cmd[22]    = eom;
        cmd[23]    = eof;
        return cmd;
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_s;
    logic          init_r;
    logic          write_r;
    logic          posted_r;
    logic          host_done_r;
    logic [RW-1:0] host_rdata_r;
    logic [1:0]    host_err_r;
    logic          req_valid_r;
    logic [CW-1:0] req_cmd_r;
    logic [AW-1:0] req_dstaddr_r;
    logic [AW-1:0] req_srcaddr_r;
    logic [DW-1:0] req_data_r;
    logic [4:0]    req_opcode_s;
    logic          host_fire_s;
    logic          timeout_s;
    logic [1:0]    resp_err_s;
    logic          unused_s;

    // init_r holds host_ready and uhost_resp_ready low for the first cycle
    // after reset, so both leave reset at 0 even though the FSM sits in IDLE.
    assign host_ready       = init_r && (state_r == ST_IDLE);
    // Responses are drained in every state: WAIT takes them as the match,
    // all other states discard them as stray or late.
    assign uhost_resp_ready = init_r && ((state_r == ST_IDLE) || (state_r == ST_REQ) ||
                                         (state_r == ST_WAIT) || (state_r == ST_DONE));
    assign host_fire_s      = host_ready && host_valid;
    assign resp_err_s       = uhost_resp_cmd[26:25];
    assign unused_s         = ^{uhost_resp_cmd, uhost_resp_dstaddr,
                                uhost_resp_srcaddr, uhost_resp_data};

    assign host_done         = host_done_r;
    assign host_rdata        = host_rdata_r;
    assign host_err          = host_err_r;
    assign uhost_req_valid   = req_valid_r;
    assign uhost_req_cmd     = req_cmd_r;
    assign uhost_req_dstaddr = req_dstaddr_r;
    assign uhost_req_srcaddr = req_srcaddr_r;
    assign uhost_req_data    = req_data_r;

`ifdef UMI_REG_HOST_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    logic [15:0] cnt_r;

    // A response arriving in the expiry cycle takes priority over the timeout.
    assign timeout_s = (state_r == ST_WAIT) && !uhost_resp_valid &&
                       ((cnt_r + 16'd1) == TIMEOUT_CNT);

    // Response-wait counter: cleared on the request handshake, counts WAIT cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 16'd0;
        end else if ((state_r == ST_REQ) && uhost_req_ready) begin
            cnt_r <= 16'd0;
        end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Request opcode selection from the host access type.
    always_comb begin
        req_opcode_s = UMI_REQ_READ;
        if (host_write && host_posted) begin
            req_opcode_s = UMI_REQ_POSTED;
        end else if (host_write) begin
            req_opcode_s = UMI_REQ_WRITE;
        end else begin
            req_opcode_s = UMI_REQ_READ;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (host_fire_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (uhost_req_ready) begin
                    state_s = posted_r ? ST_DONE : ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (uhost_resp_valid || timeout_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, request capture and host-side completion registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            init_r        <= 1'b0;
            write_r       <= 1'b0;
            posted_r      <= 1'b0;
            host_done_r   <= 1'b0;
            host_rdata_r  <= {RW{1'b0}};
            host_err_r    <= 2'b00;
            req_valid_r   <= 1'b0;
            req_cmd_r     <= {CW{1'b0}};
            req_dstaddr_r <= {AW{1'b0}};
            req_srcaddr_r <= {AW{1'b0}};
            req_data_r    <= {DW{1'b0}};
        end else begin
            state_r     <= state_s;
            init_r      <= 1'b1;
            host_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (host_fire_s) begin
                        write_r       <= host_write;
                        posted_r      <= host_write && host_posted;
                        req_valid_r   <= 1'b1;
                        req_cmd_r     <= umi_pack(req_opcode_s, REQ_SIZE, 8'd0, 1'b1, 1'b1);
                        req_dstaddr_r <= host_addr;
                        req_srcaddr_r <= SRCADDR;
                        req_data_r    <= host_write ? DW'(host_wdata) : {DW{1'b0}};
                    end
                end
                ST_REQ: begin
                    if (uhost_req_ready) begin
                        req_valid_r <= 1'b0;
                        if (posted_r) begin
                            host_done_r <= 1'b1;
                            host_err_r  <= 2'b00;
                        end
                    end
                end
                ST_WAIT: begin
                    if (uhost_resp_valid) begin
                        if (!write_r) begin
                            host_rdata_r <= uhost_resp_data[RW-1:0];
                        end
                        host_err_r  <= {(resp_err_s != 2'b00), 1'b0};
                        host_done_r <= 1'b1;
                    end else if (timeout_s) begin
                        host_err_r  <= 2'b01;
                        host_done_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    host_done_r <= 1'b0;
                end
                default: begin
                    host_done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_umi_reg_host.sv
// Scoreboard bench for umi_reg_host: stimulus pushes expected requests and
// completions into queues; a monitor pops and compares them as the DUT
// presents request handshakes and host_done pulses.
module tb_umi_reg_host;

    localparam int            DW      = 256;
    localparam int            AW      = 64;
    localparam int            CW      = 32;
    localparam int            RW      = 32;
    localparam int            TIMEOUT = 20;
    localparam logic [AW-1:0] SRCADDR = 64'h0000_0000_0000_1000;

    logic          clk;
    logic          reset;
    logic          host_valid;
    logic          host_write;
    logic          host_posted;
    logic [AW-1:0] host_addr;
    logic [RW-1:0] host_wdata;
    logic          host_ready;
    logic          host_done;
    logic [RW-1:0] host_rdata;
    logic [1:0]    host_err;
    logic          uhost_req_valid;
    logic [CW-1:0] uhost_req_cmd;
    logic [AW-1:0] uhost_req_dstaddr;
    logic [AW-1:0] uhost_req_srcaddr;
    logic [DW-1:0] uhost_req_data;
    logic          uhost_req_ready;
    logic          uhost_resp_valid;
    logic [CW-1:0] uhost_resp_cmd;
    logic [AW-1:0] uhost_resp_dstaddr;
    logic [AW-1:0] uhost_resp_srcaddr;
    logic [DW-1:0] uhost_resp_data;
    logic          uhost_resp_ready;

    typedef struct {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
    } req_t;

    // kind: 0 = done follows response handshake, 1 = follows request
    // handshake (posted), 2 = TIMEOUT cycles after entering WAIT
    typedef struct {
        logic [RW-1:0] rdata;
        logic [1:0]    err;
        int            kind;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    umi_reg_host #(
        .DW(DW), .AW(AW), .CW(CW), .RW(RW), .SRCADDR(SRCADDR), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .host_valid        (host_valid),
        .host_write        (host_write),
        .host_posted       (host_posted),
        .host_addr         (host_addr),
        .host_wdata        (host_wdata),
        .host_ready        (host_ready),
        .host_done         (host_done),
        .host_rdata        (host_rdata),
        .host_err          (host_err),
        .uhost_req_valid   (uhost_req_valid),
        .uhost_req_cmd     (uhost_req_cmd),
        .uhost_req_dstaddr (uhost_req_dstaddr),
        .uhost_req_srcaddr (uhost_req_srcaddr),
        .uhost_req_data    (uhost_req_data),
        .uhost_req_ready   (uhost_req_ready),
        .uhost_resp_valid  (uhost_resp_valid),
        .uhost_resp_cmd    (uhost_resp_cmd),
        .uhost_resp_dstaddr(uhost_resp_dstaddr),
        .uhost_resp_srcaddr(uhost_resp_srcaddr),
        .uhost_resp_data   (uhost_resp_data),
        .uhost_resp_ready  (uhost_resp_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_host_ready"}, host_ready, 1'b0);
        check({tag, "_host_done"},  host_done,  1'b0);
        check({tag, "_host_rdata"}, host_rdata, 32'h0);
        check({tag, "_host_err"},   host_err,   2'b00);
        check({tag, "_req_valid"},  uhost_req_valid, 1'b0);
        check({tag, "_req_cmd"},    uhost_req_cmd, 32'h0);
        check({tag, "_req_dst"},    uhost_req_dstaddr, 64'h0);
        check({tag, "_req_src"},    uhost_req_srcaddr, 64'h0);
        check({tag, "_req_data"},   uhost_req_data, 256'h0);
        check({tag, "_resp_ready"}, uhost_resp_ready, 1'b0);
    endtask

    // One host access with a scripted device: stall = cycles of req_ready
    // low, delay = WAIT cycles before the response, respond = send response.
    task automatic access(input logic wr, input logic posted, input logic [AW-1:0] addr,
                          input logic [RW-1:0] wdata, input int stall, input int delay,
                          input logic respond, input logic [RW-1:0] rsp_data,
                          input logic [1:0] rsp_err, input logic [RW-1:0] exp_rdata,
                          input logic [1:0] exp_err, input int kind, input logic expect_done);
        req_t  r;
        done_t d;
        int    n;
        if (wr && posted) r.cmd = 32'h00C0_0045;
        else if (wr)      r.cmd = 32'h00C0_0043;
        else              r.cmd = 32'h00C0_0041;
        r.dst  = addr;
        r.data = wr ? {224'h0, wdata} : 256'h0;
        req_q.push_back(r);
        if (expect_done) begin
            d.rdata = exp_rdata;
            d.err   = exp_err;
            d.kind  = kind;
            done_q.push_back(d);
        end
        host_valid  = 1'b1;
        host_write  = wr;
        host_posted = posted;
        host_addr   = addr;
        host_wdata  = wdata;
        n = 0;
        while (!host_ready && n < 50) begin
            tick();
            n++;
        end
        if (!host_ready) check("host_ready_wait", host_ready, 1'b1);
        tick();
        // Scramble the host inputs so the request must come from captured state.
        host_valid  = 1'b0;
        host_write  = 1'b0;
        host_posted = 1'b0;
        host_addr   = 64'hFFFF_FFFF_FFFF_FFFF;
        host_wdata  = 32'hFFFF_FFFF;
        repeat (stall) begin
            check("stall_valid", uhost_req_valid, 1'b1);
            check("stall_cmd",   uhost_req_cmd,   r.cmd);
            check("stall_dst",   uhost_req_dstaddr, r.dst);
            check("stall_data",  uhost_req_data,  r.data);
            tick();
        end
        uhost_req_ready = 1'b1;
        tick();
        uhost_req_ready = 1'b0;
        if (respond) begin
            repeat (delay) tick();
            uhost_resp_valid = 1'b1;
            uhost_resp_cmd   = 32'h0000_0002 | ({30'h0, rsp_err} << 25);
            uhost_resp_data  = {224'h0, rsp_data};
            tick();
            uhost_resp_valid = 1'b0;
            uhost_resp_data  = 256'h0;
        end
        n = 0;
        while (done_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (done_q.size() != 0) begin
            check("done_wait", done_q.size(), 0);
            done_q.delete();
        end
        if (expect_done) repeat (2) tick();
    endtask

    task automatic stray();
        uhost_resp_valid = 1'b1;
        uhost_resp_cmd   = 32'h0000_0002;
        uhost_resp_data  = {224'h0, 32'h9999_9999};
        check("stray_ready", uhost_resp_ready, 1'b1);
        tick();
        uhost_resp_valid = 1'b0;
        uhost_resp_data  = 256'h0;
        repeat (4) tick();
    endtask

    // Monitor: compares request handshakes and host_done pulses against queues.
    initial begin : monitor
        int    last_host = -10;
        int    last_req  = -10;
        int    last_resp = -10;
        int    exp_cyc;
        logic  prev_v = 1'b0;
        req_t  r;
        done_t d;
        forever begin
            @(negedge clk);
            if (uhost_req_valid && !prev_v) check("req_latency", cyc, last_host + 1);
            prev_v = uhost_req_valid;
            if (host_valid && host_ready) last_host = cyc;
            if (uhost_req_valid && uhost_req_ready) begin
                last_req = cyc;
                if (req_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: cmd %0h with no request expected", uhost_req_cmd);
                end else begin
                    r = req_q.pop_front();
                    check("req_cmd",  uhost_req_cmd,     r.cmd);
                    check("req_dst",  uhost_req_dstaddr, r.dst);
                    check("req_src",  uhost_req_srcaddr, SRCADDR);
                    check("req_data", uhost_req_data,    r.data);
                end
            end
            if (uhost_resp_valid && uhost_resp_ready) last_resp = cyc;
            if (host_done) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: host_done at cycle %0d, none expected", cyc);
                end else begin
                    d = done_q.pop_front();
                    check("done_rdata", host_rdata, d.rdata);
                    check("done_err",   host_err,   d.err);
                    if (d.kind == 0)      exp_cyc = last_resp + 1;
                    else if (d.kind == 1) exp_cyc = last_req + 1;
                    else                  exp_cyc = last_req + 1 + TIMEOUT;
                    check("done_latency", cyc, exp_cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset              = 1'b1;
        host_valid         = 1'b0;
        host_write         = 1'b0;
        host_posted        = 1'b0;
        host_addr          = 64'h0;
        host_wdata         = 32'h0;
        uhost_req_ready    = 1'b0;
        uhost_resp_valid   = 1'b0;
        uhost_resp_cmd     = 32'h0;
        uhost_resp_dstaddr = 64'h0;
        uhost_resp_srcaddr = 64'h0;
        uhost_resp_data    = 256'h0;
        repeat (3) tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        check("rst_release_ready", host_ready, 1'b0);
        tick();
        check("ready_after_reset", host_ready, 1'b1);

        // Write, zero-wait device
        access(1'b1, 1'b0, 64'h4, 32'hA5A5_0001, 0, 0, 1'b1, 32'h0, 2'b00,
               32'h0, 2'b00, 0, 1'b1);
        // Read with 3-cycle request stall and 5-cycle response delay
        access(1'b0, 1'b0, 64'h0, 32'h0, 3, 5, 1'b1, 32'h1234_5678, 2'b00,
               32'h1234_5678, 2'b00, 0, 1'b1);
        // Posted write, then a stray response
        access(1'b1, 1'b1, 64'h8, 32'h0000_00C3, 0, 0, 1'b0, 32'h0, 2'b00,
               32'h1234_5678, 2'b00, 1, 1'b1);
        stray();
        // Reads with nonzero response error
        access(1'b0, 1'b0, 64'hC, 32'h0, 0, 0, 1'b1, 32'hDEAD_BEEF, 2'b10,
               32'hDEAD_BEEF, 2'b10, 0, 1'b1);
        access(1'b0, 1'b0, 64'h20, 32'h0, 0, 1, 1'b1, 32'h5555_AAAA, 2'b01,
               32'h5555_AAAA, 2'b10, 0, 1'b1);
`ifdef UMI_REG_HOST_TIMEOUT_EN
        // Read with no response: timeout, rdata unchanged, late response dropped
        access(1'b0, 1'b0, 64'h10, 32'h0, 0, 0, 1'b0, 32'h0, 2'b00,
               32'h5555_AAAA, 2'b01, 2, 1'b1);
        repeat (3) tick();
        stray();
`else
        // Without the timeout the host waits well past TIMEOUT for the response
        access(1'b0, 1'b0, 64'h10, 32'h0, 0, 40, 1'b1, 32'hCAFE_0001, 2'b00,
               32'hCAFE_0001, 2'b00, 0, 1'b1);
`endif
        // Reset while in WAIT
        access(1'b0, 1'b0, 64'h18, 32'h0, 0, 0, 1'b0, 32'h0, 2'b00,
               32'h0, 2'b00, 0, 1'b0);
        tick();
        check("wait_ready_low", host_ready, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        reset = 1'b0;
        check("midrst_release_ready", host_ready, 1'b0);
        tick();
        stray();
        // New read after reset completes normally
        access(1'b0, 1'b0, 64'h14, 32'h0, 0, 0, 1'b1, 32'h0000_0077, 2'b00,
               32'h0000_0077, 2'b00, 0, 1'b1);
        check("req_queue_empty", req_q.size(), 0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
